// File: rtl/cv32e_obi_mem_arbiter.sv
// cv32e_obi_mem_arbiter
// Shares one OBI-style memory port between the instruction requester (ID 0)
// and the data requester (ID 1). Request selection is combinational. An
// unanswered request locks the selection until it is granted. Granted IDs are
// queued in order so each response is returned to the requester that issued it.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, contention is
// resolved round-robin. When it is undefined, data has fixed priority over
// instruction.
module cv32e_obi_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e               state_r;
  state_e               state_nxt_s;
  logic                 hold_id_r;
  logic                 hold_id_nxt_s;
  logic [MAX_OUTST-1:0] id_fifo_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;

  logic                 prio_s;
  logic                 sel_id_s;
  logic                 sel_req_s;
  logic                 room_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 head_id_s;

  // Advance a FIFO pointer, wrapping modulo MAX_OUTST (which need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = ptr + PTR_W'(1);
    end
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_r;

  // Priority pointer: after each handshake of the pointed ID, hand priority to the other side.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_r <= 1'b1;
    end else if (push_s && (sel_id_s == prio_r)) begin
      prio_r <= ~prio_r;
    end
  end

  assign prio_s = prio_r;
`else
  assign prio_s = 1'b1;
`endif

  // Requester selection: follow the lock in HOLD; otherwise arbitrate or take the lone requester.
  always_comb begin
    sel_id_s = 1'b1;
    case (state_r)
      HOLD: begin
        sel_id_s = hold_id_r;
      end
      IDLE: begin
        if (instr_req_i && data_req_i) begin
          sel_id_s = prio_s;
        end else if (instr_req_i) begin
          sel_id_s = 1'b0;
        end else begin
          sel_id_s = 1'b1;
        end
      end
      default: begin
        sel_id_s = 1'b1;
      end
    endcase
  end

  // A response retires only when an ID is actually outstanding. Stray rvalids are ignored.
  assign pop_s     = rst_ni && mem_rvalid_i && (count_r != {CNT_W{1'b0}});
  assign room_s    = (count_r < CNT_MAX) || pop_s;
  assign sel_req_s = sel_id_s ? data_req_i : instr_req_i;
  assign mem_req_o = rst_ni && sel_req_s && room_s;
  assign push_s    = mem_req_o && mem_gnt_i;

  // Forward the selected requester's address and attributes. Fetches are full-word reads.
  assign mem_addr_o  = sel_id_s ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = sel_id_s ? data_we_i    : 1'b0;
  assign mem_be_o    = sel_id_s ? data_be_i    : 4'hF;
  assign mem_wdata_o = sel_id_s ? data_wdata_i : 32'h0000_0000;

  assign instr_gnt_o = push_s && (sel_id_s == 1'b0);
  assign data_gnt_o  = push_s && (sel_id_s == 1'b1);

  // Route each response to the ID at the head of the in-order queue.
  assign head_id_s      = id_fifo_r[rd_ptr_r];
  assign instr_rvalid_o = pop_s && (head_id_s == 1'b0);
  assign data_rvalid_o  = pop_s && (head_id_s == 1'b1);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  // Lock control: a request left ungranted freezes the selection until it is granted.
  always_comb begin
    state_nxt_s   = state_r;
    hold_id_nxt_s = hold_id_r;
    case (state_r)
      IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_nxt_s   = HOLD;
          hold_id_nxt_s = sel_id_s;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      HOLD: begin
        // Also release the lock if the locked requester withdraws, so the port never stalls.
        if (mem_gnt_i || !mem_req_o) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        hold_id_nxt_s = 1'b0;
      end
    endcase
  end

  // State and locked-ID registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      hold_id_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      hold_id_r <= hold_id_nxt_s;
    end
  end

  // Outstanding-ID queue: push granted IDs, pop on each response, and keep the count in step.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_fifo_r <= {MAX_OUTST{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        id_fifo_r[wr_ptr_r] <= sel_id_s;
        wr_ptr_r            <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: doc/cv32e_obi_mem_arbiter.md
CV32E_OBI_MEM_ARBITER -- requirements
Module: cv32e_obi_mem_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the address width of all ports.
REQ-002 The block SHALL have parameter MAX_OUTST, default 2, meaning the maximum number of outstanding granted transactions; the legal range is 1..4.

Ports:
REQ-003 clk_i  in  1  The single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  Asynchronous reset, active-low.
REQ-005 instr_req_i in 1 / instr_addr_i in ADDR_W  Instruction-side request and address.
REQ-006 instr_gnt_o out 1 / instr_rvalid_o out 1 / instr_rdata_o out 32  Instruction-side grant and response.
REQ-007 data_req_i in 1 / data_addr_i in ADDR_W / data_we_i in 1 / data_be_i in 4 / data_wdata_i in 32  Data-side request.
REQ-008 data_gnt_o out 1 / data_rvalid_o out 1 / data_rdata_o out 32  Data-side grant and response.
REQ-009 mem_req_o out 1 / mem_addr_o out ADDR_W / mem_we_o out 1 / mem_be_o out 4 / mem_wdata_o out 32  Shared memory request.
REQ-010 mem_gnt_i in 1 / mem_rvalid_i in 1 / mem_rdata_i in 32  Shared memory grant and response.

Function
REQ-011 The block SHALL share one OBI-style memory port between the instruction requester (ID 0) and the data requester (ID 1).
REQ-012 Instruction requests SHALL be driven with mem_we_o=0, mem_be_o=4'hF and mem_wdata_o=0.
REQ-013 Request selection SHALL be combinational, with zero added latency from *_req_i to mem_req_o.
REQ-014 mem_req_o SHALL be asserted only when the selected requester's req is high and the outstanding count < MAX_OUTST (or a response retires in the same cycle).
REQ-015 The grant SHALL be routed only to the selected requester: *_gnt_o = mem_gnt_i & mem_req_o & selected; the unselected gnt SHALL be 0.
REQ-016 Lock: if mem_req_o=1 and mem_gnt_i=0, the selection SHALL be frozen until that request is granted; the address and attributes SHALL stay stable even if the other side raises req.
REQ-017 States: IDLE (no lock) and HOLD (locked to ID). IDLE->HOLD on req without gnt. HOLD->IDLE on gnt.
REQ-018 ID FIFO: on each mem handshake (req&gnt), the block SHALL push the granted ID into an in-order FIFO of depth MAX_OUTST.
REQ-019 On mem_rvalid_i, the block SHALL pop the FIFO head and route rvalid/rdata to that ID; the other side's rvalid SHALL be 0.
REQ-020 *_rdata_o SHALL mirror mem_rdata_i unconditionally.
REQ-021 Simultaneous push and pop in the same cycle SHALL leave the count unchanged, and a push SHALL be allowed when the FIFO is full only if a pop occurs that cycle.
REQ-022 mem_rvalid_i with an empty FIFO is illegal: the block SHALL drop it (no rvalid output) and SHALL leave the count at 0.
REQ-023 FIFO pointers SHALL wrap modulo MAX_OUTST, and the count SHALL be $clog2(MAX_OUTST+1) bits wide.

Reset
REQ-024 Asserting rst_ni low SHALL immediately clear the FIFO, set count=0, state=IDLE and priority pointer=data (ID 1).
REQ-025 During reset, all *_gnt_o, *_rvalid_o and mem_req_o SHALL be 0.
REQ-026 Reset mid-transaction SHALL discard outstanding IDs, and responses arriving after reset release SHALL be dropped per REQ-022.

Configuration
REQ-027 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-028 Macro defined: on contention in IDLE, the block SHALL grant the ID indicated by the priority pointer, and the pointer SHALL toggle to the other ID after each handshake of the pointed ID.
REQ-029 Macro undefined: the block SHALL use fixed priority, data (ID 1) over instruction (ID 0), and the pointer register SHALL be absent.
REQ-030 In both modes, a lone requester SHALL be selected immediately.

Verification
REQ-031 Lone instr req, addr 0x100, gnt=1, rvalid next cycle with rdata 0xDEADBEEF -> instr_gnt_o=1, instr_rvalid_o=1 and instr_rdata_o=0xDEADBEEF, with data_rvalid_o=0 throughout.
REQ-032 Both reqs high, gnt=1 every cycle, 4 cycles -> with ARB_ROUND_ROBIN_EN, grant order is D,I,D,I; without it, the order is D,D,D,D.
REQ-033 Instr req with gnt held 0 for 3 cycles, data req rising in cycle 1 -> mem_addr_o stays the instr address until gnt, and data is served after.
REQ-034 MAX_OUTST=2, two grants with no rvalid -> mem_req_o=0 on a third req; when rvalid and a new gnt occur in the same cycle, the third request is accepted and the count stays 2.
REQ-035 Interleaved grants I,D,I, then 3 rvalids -> responses are routed I,D,I in order.
REQ-036 rst_ni pulsed low with 2 outstanding, then 1 stray rvalid -> no *_rvalid_o is asserted and the count is 0.
